outputc: RTL and testbench
==========================

// Module: outputc
// PURPOSE
// - Output-channel controller for one physical output port of the router: the transmit end of the link whose receive end is the input controller.
// - Arbitrates among the 5 input controllers requesting this port and forwards the winning flit onto the link.
// - Tracks downstream buffer space per VC with credits and publishes per-VC ready/lock status back to all input VCs.
// PARAMETERS
// ROUTERID      0   router identifier; debug display only
// PCHID         0   physical output port number this instance serves (matched against port_i)
// CREDIT_DEPTH  4   downstream FIFO depth per VC = initial and maximum credit count (1..15)
// PORTS
// clk       in   1            clock
// rst_      in   1            asynchronous active-low reset
// idata_i   in   `DATAW+1     flit from input controller i (i=0..4); valid only when ivalid_i
// ivalid_i  in   1            input controller i presents a flit this cycle
// ivch_i    in   `VCHW+1      output VC requested by input controller i
// req_i     in   1            input controller i requests output port port_i
// port_i    in   `PORTW+1     requested output port of input controller i
// grt_i     out  1            grant to input controller i (combinational, same cycle as req)
// iack      in   `VCH+1       per-VC credit return from downstream (its oack); 1 = one slot freed
// odata     out  `DATAW+1     flit on link; registered
// ovalid    out  1            link flit valid; registered
// ovch      out  `VCHW+1      link VC; registered
// ordy      out  `VCH+1       ordy[v]=1 when credit[v]!=0
// olck      out  `VCH+1       olck[v]=1 while a packet is in flight on downstream VC v
// BEHAVIOUR
// - Reset: grt_*=0, odata=0, ovalid=0, ovch=0, credit[v]=CREDIT_DEPTH, ordy=all 1, olck=0, rr pointer=0.
// - Eligible i: req_i && port_i==PCHID. Round-robin arbiter, at most one grt_i high per cycle.
// - Search starts at pointer p; after a grant to i, p <= (i+1) mod 5; with no grant p holds.
// - Input controllers only request VC v with ordy[v]=1; the arbiter does not recheck credits.
// - Launch: ivalid of the granted input registers idata/ivch into odata/ovch with ovalid=1 on the next edge (1-cycle latency).
// - No launch => ovalid=0, odata=0 next cycle. ivalid from a non-granted input is ignored.
// - Credit per VC, 4-bit counter:
//   - launch on v: decrement.
//   - iack[v]: increment.
//   - both in the same cycle: unchanged.
//   - increment at CREDIT_DEPTH: saturates, no change.
//   - decrement at 0: prevented by contract; counter holds at 0.
// - ordy is derived combinationally from the registered counters, so it reflects updates one cycle after launch/iack.
// - Lock FSM per VC, states IDLE/BUSY:
//   - IDLE->BUSY on launch of a TYPE_HEAD flit on v.
//   - BUSY->IDLE on launch of TYPE_TAIL on v.
//   - TYPE_HEADTAIL leaves the state IDLE.
//   - TYPE_DATA in IDLE leaves the state IDLE.
//   - olck[v] = (state==BUSY). Flit type is taken from idata[`TYPE_MSB:`TYPE_LSB].
// - Reset asserted mid-packet: all state returns to reset values immediately; in-flight packets are discarded by the system-level reset.
// CONFIGURATION
// - OUTC_CREDIT_CHK_EN defined:
//   - Adds output cerr (1 bit, sticky until reset).
//   - cerr sets on iack[v] when credit[v]==CREDIT_DEPTH (overflow).
//   - cerr sets on launch on v when credit[v]==0 (underflow).
//   - Simulation $display of ROUTERID/PCHID/v on each set.
// - OUTC_CREDIT_CHK_EN undefined: no cerr port; saturation/hold behaviour unchanged; no checks.
// TESTING
// - Reset -> ordy=2'b11, olck=0, ovalid=0, credit[0]=credit[1]=4.
// - req_2 alone (port_2=PCHID), HEAD on VC1 -> grt_2=1 same cycle; next cycle ovalid=1, ovch=1, olck[1]=1, credit[1]=3.
// - req_0 and req_3 held continuously, single-flit HEADTAIL packets -> grants alternate 0,3,0,3; p wraps 4->0.
// - 4 launches on VC0 without iack -> ordy[0]=0; iack[0]=1 -> ordy[0]=1 next cycle.
// - Launch and iack on VC0 in the same cycle at credit 2 -> credit stays 2.
// - With OUTC_CREDIT_CHK_EN: iack[1] at credit 4 -> cerr=1 and stays 1 until rst_=0; credit remains 4.

Source files
------------

// File: rtl/outputc.sv
// outputc: transmit-side controller for one router output port.
// Round-robin arbitration among 5 input controllers, registered flit launch
// onto the link, per-VC credit counters (ordy) and per-VC packet lock (olck).
// Optional build macro OUTC_CREDIT_CHK_EN adds a sticky credit-error output cerr.

`ifndef DATAW
`define DATAW 35
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 35
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 34
`endif

module outputc #(
  parameter int ROUTERID     = 0,
  parameter int PCHID        = 0,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [`DATAW:0]   idata_0,
  input  logic [`DATAW:0]   idata_1,
  input  logic [`DATAW:0]   idata_2,
  input  logic [`DATAW:0]   idata_3,
  input  logic [`DATAW:0]   idata_4,
  input  logic              ivalid_0,
  input  logic              ivalid_1,
  input  logic              ivalid_2,
  input  logic              ivalid_3,
  input  logic              ivalid_4,
  input  logic [`VCHW:0]    ivch_0,
  input  logic [`VCHW:0]    ivch_1,
  input  logic [`VCHW:0]    ivch_2,
  input  logic [`VCHW:0]    ivch_3,
  input  logic [`VCHW:0]    ivch_4,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              req_3,
  input  logic              req_4,
  input  logic [`PORTW:0]   port_0,
  input  logic [`PORTW:0]   port_1,
  input  logic [`PORTW:0]   port_2,
  input  logic [`PORTW:0]   port_3,
  input  logic [`PORTW:0]   port_4,
  output logic              grt_0,
  output logic              grt_1,
  output logic              grt_2,
  output logic              grt_3,
  output logic              grt_4,
  input  logic [`VCH:0]     iack,
  output logic [`DATAW:0]   odata,
  output logic              ovalid,
  output logic [`VCHW:0]    ovch,
  output logic [`VCH:0]     ordy,
  output logic [`VCH:0]     olck
`ifdef OUTC_CREDIT_CHK_EN
  ,
  output logic              cerr
`endif
);

  localparam int NIN = 5;
  localparam int NVC = `VCH + 1;
  localparam logic [`PORTW:0] PCH  = PCHID[`PORTW:0];
  localparam logic [3:0]      CMAX = CREDIT_DEPTH[3:0];

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;

  typedef enum logic {LK_IDLE, LK_BUSY} lock_t;

  logic [`DATAW:0] idata [NIN];
  logic [`VCHW:0]  ivch  [NIN];
  logic [NIN-1:0]  ivalid;
  logic [NIN-1:0]  elig;

  assign idata  = '{idata_0, idata_1, idata_2, idata_3, idata_4};
  assign ivch   = '{ivch_0, ivch_1, ivch_2, ivch_3, ivch_4};
  assign ivalid = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
  assign elig   = {req_4 && (port_4 == PCH), req_3 && (port_3 == PCH),
                   req_2 && (port_2 == PCH), req_1 && (port_1 == PCH),
                   req_0 && (port_0 == PCH)};

  logic [2:0]       rr_ptr;
  logic [NIN-1:0]   grant;
  logic             any_grant;
  logic [2:0]       win;

  // Round-robin search starting at rr_ptr; first eligible requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    any_grant = 1'b0;
    win       = '0;
    for (int k = 0; k < NIN; k++) begin
      logic [3:0] idx;
      idx = 4'(rr_ptr) + 4'(k);
      if (idx >= 4'(NIN)) idx = idx - 4'(NIN);
      if (!any_grant && elig[idx[2:0]]) begin
        any_grant = 1'b1;
        win       = idx[2:0];
      end
    end
    if (any_grant) grant[win] = 1'b1;
  end

  assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grant;

  logic [`DATAW:0] sel_data;
  logic [`VCHW:0]  sel_vch;
  logic            launch;

  // Steer the winner's flit and VC toward the link register.
  always_comb begin
    sel_data = '0;
    sel_vch  = '0;
    launch   = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (grant[i]) begin
        sel_data = idata[i];
        sel_vch  = ivch[i];
        launch   = ivalid[i];
      end
    end
  end

  // Pointer moves past the granted input; holds when nobody is granted.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
      rr_ptr <= (win == 3'(NIN - 1)) ? 3'd0 : win + 3'd1;
    end
  end

  // Link register: one-cycle launch latency, zeroed when idle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
    end else begin
      ovalid <= launch;
      odata  <= launch ? sel_data : '0;
      ovch   <= launch ? sel_vch  : '0;
    end
  end

  logic [NVC-1:0] dec;
  logic [3:0]     credit [NVC];

  // Per-VC launch strobe.
  always_comb begin
    dec = '0;
    for (int v = 0; v < NVC; v++) dec[v] = launch && (sel_vch == (`VCHW+1)'(v));
  end

  // Credit counters: launch consumes, iack returns, simultaneous cancels.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      // NOTE: this is a small register array, not a RAM, so every entry is reset explicitly.
      for (int v = 0; v < NVC; v++) credit[v] <= CMAX;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        case ({dec[v], iack[v]})
          2'b10:   if (credit[v] != 4'd0) credit[v] <= credit[v] - 4'd1;
          2'b01:   if (credit[v] != CMAX) credit[v] <= credit[v] + 4'd1;
          default: credit[v] <= credit[v];
        endcase
      end
    end
  end

  lock_t      lock_q [NVC];
  lock_t      lock_d [NVC];
  logic [1:0] ftype;

  assign ftype = sel_data[`TYPE_MSB:`TYPE_LSB];

  // Lock next-state: HEAD opens a packet on its VC, TAIL closes it.
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      lock_d[v] = lock_q[v];
      if (dec[v]) begin
        case (lock_q[v])
          LK_IDLE: if (ftype == FT_HEAD) lock_d[v] = LK_BUSY;
          LK_BUSY: if (ftype == FT_TAIL) lock_d[v] = LK_IDLE;
          default: lock_d[v] = LK_IDLE;
        endcase
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) lock_q[v] <= LK_IDLE;
    end else begin
      for (int v = 0; v < NVC; v++) lock_q[v] <= lock_d[v];
    end
  end

  // Status published back to the input VCs.
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      ordy[v] = (credit[v] != 4'd0);
      olck[v] = (lock_q[v] == LK_BUSY);
    end
  end

`ifdef OUTC_CREDIT_CHK_EN
  // Sticky credit error: return at full credit or launch at zero credit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cerr <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if ((iack[v] && credit[v] == CMAX) || (dec[v] && credit[v] == 4'd0)) begin
          cerr <= 1'b1;
          $display("outputc credit error: router %0d port %0d vc %0d", ROUTERID, PCHID, v);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_outputc.sv
// Scoreboard bench for outputc: stimulus pushes expected link flits into a
// queue, a negedge monitor pops and compares whenever ovalid is seen.

`ifndef DATAW
`define DATAW 35
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 35
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 34
`endif

module tb_outputc;

  localparam logic [1:0] T_DATA = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic              clk = 1'b0;
  logic              rst_;
  logic [`DATAW:0]   idata [5];
  logic [`VCHW:0]    ivch  [5];
  logic [`PORTW:0]   port  [5];
  logic [4:0]        req;
  logic [4:0]        ivalid;
  logic [4:0]        grt;
  logic [`VCH:0]     iack;
  logic [`DATAW:0]   odata;
  logic              ovalid;
  logic [`VCHW:0]    ovch;
  logic [`VCH:0]     ordy;
  logic [`VCH:0]     olck;
`ifdef OUTC_CREDIT_CHK_EN
  logic              cerr;
`endif

  outputc #(.ROUTERID(0), .PCHID(0), .CREDIT_DEPTH(4)) dut (
    .clk(clk), .rst_(rst_),
    .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]), .idata_3(idata[3]), .idata_4(idata[4]),
    .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]), .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
    .ivch_0(ivch[0]), .ivch_1(ivch[1]), .ivch_2(ivch[2]), .ivch_3(ivch[3]), .ivch_4(ivch[4]),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
    .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
    .grt_0(grt[0]), .grt_1(grt[1]), .grt_2(grt[2]), .grt_3(grt[3]), .grt_4(grt[4]),
    .iack(iack), .odata(odata), .ovalid(ovalid), .ovch(ovch), .ordy(ordy), .olck(olck)
`ifdef OUTC_CREDIT_CHK_EN
    , .cerr(cerr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [`DATAW:0] data;
    logic [`VCHW:0]  vch;
  } flit_t;

  flit_t exp_q [$];
  flit_t exp_f;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [`DATAW:0] mk(input logic [1:0] t, input logic [`TYPE_LSB-1:0] pl);
    return {t, pl};
  endfunction

  // Monitor: every link cycle is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_ === 1'b1) begin
      if (ovalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 64'(odata), 64'h0);
        end else begin
          exp_f = exp_q.pop_front();
          check("odata", 64'(odata), 64'(exp_f.data));
          check("ovch", 64'(ovch), 64'(exp_f.vch));
        end
      end else begin
        check("idle_odata", 64'(odata), 64'h0);
      end
    end
  end

  task automatic clear_inputs();
    req = '0; ivalid = '0; iack = '0;
    for (int i = 0; i < 5; i++) begin
      idata[i] = '0; ivch[i] = '0; port[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check the grant vector mid-cycle, record the expected launch, then cross the edge.
  task automatic issue(input string name, input logic [4:0] exp_grt);
    @(negedge clk);
    check(name, 64'(grt), 64'(exp_grt));
    for (int i = 0; i < 5; i++)
      if (exp_grt[i] && ivalid[i]) exp_q.push_back('{data: idata[i], vch: ivch[i]});
    @(posedge clk); #1;
  endtask

  task automatic status(input string name, input logic [`VCH:0] e_rdy, input logic [`VCH:0] e_lck);
    check({"ordy_", name}, 64'(ordy), 64'(e_rdy));
    check({"olck_", name}, 64'(olck), 64'(e_lck));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_ = 1'b0;
    #12;
    status("reset", 2'b11, 2'b00);
    check("reset_ovalid", 64'(ovalid), 64'h0);
    check("reset_odata", 64'(odata), 64'h0);
    check("reset_grt", 64'(grt), 64'h0);
    @(posedge clk); #2;
    rst_ = 1'b1;
    tick();

    // Single requester, HEAD on VC1; input 1 asks for a different port.
    req[2] = 1'b1; port[2] = 3'd0; ivalid[2] = 1'b1; ivch[2] = 1'b1; idata[2] = mk(T_HEAD, 34'h2A);
    req[1] = 1'b1; port[1] = 3'd3; ivalid[1] = 1'b1; ivch[1] = 1'b0; idata[1] = mk(T_HEAD, 34'h1BAD);
    issue("grant_head", 5'b00100);
    status("after_head", 2'b11, 2'b10);
    idata[2] = mk(T_TAIL, 34'h2B);
    issue("grant_tail", 5'b00100);
    status("after_tail", 2'b11, 2'b00);
    clear_inputs();
    req[1] = 1'b1; port[1] = 3'd3; ivalid[1] = 1'b1;
    issue("no_eligible", 5'b00000);

    // Two requesters held; pointer is 3 after the grants to input 2.
    clear_inputs();
    req[0] = 1'b1; req[3] = 1'b1; ivalid[0] = 1'b1; ivalid[3] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idata[0] = mk(T_HT, 34'(32'h100 + j));
      idata[3] = mk(T_HT, 34'(32'h300 + j));
      issue($sformatf("rr_%0d", j), (j % 2 == 0) ? 5'b01000 : 5'b00001);
      status($sformatf("vc0_drain_%0d", j), {1'b1, (j < 3) ? 1'b1 : 1'b0}, 2'b00);
    end

    // Credit return restores ordy[0], then bring VC0 to credit 2.
    clear_inputs();
    iack[0] = 1'b1;
    tick();
    iack = '0;
    status("vc0_return", 2'b11, 2'b00);
    iack[0] = 1'b1;
    tick();
    iack = '0;

    // Simultaneous launch and iack at credit 2, then two launches drain it exactly.
    req[1] = 1'b1; ivalid[1] = 1'b1; ivch[1] = 1'b0; idata[1] = mk(T_HT, 34'h1F0);
    iack[0] = 1'b1;
    issue("grant_simul", 5'b00010);
    iack = '0;
    idata[1] = mk(T_HT, 34'h1F1);
    issue("drain_a", 5'b00010);
    status("credit_1", 2'b11, 2'b00);
    idata[1] = mk(T_HT, 34'h1F2);
    issue("drain_b", 5'b00010);
    status("credit_0", 2'b10, 2'b00);

    // Grant without ivalid: nothing goes on the link.
    ivalid[1] = 1'b0;
    issue("grant_no_valid", 5'b00010);
    clear_inputs();

    // VC1: refill to 4, one extra iack must saturate.
    iack[1] = 1'b1;
    tick();
    tick();
`ifdef OUTC_CREDIT_CHK_EN
    check("cerr_clear", 64'(cerr), 64'h0);
`endif
    tick();
    iack = '0;
`ifdef OUTC_CREDIT_CHK_EN
    check("cerr_set", 64'(cerr), 64'h1);
`endif
    req[4] = 1'b1; ivalid[4] = 1'b1; ivch[4] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idata[4] = mk((j == 1) ? T_HT : T_DATA, 34'(32'h400 + j));
      issue($sformatf("vc1_launch_%0d", j), 5'b10000);
      status($sformatf("vc1_drain_%0d", j), {(j < 3) ? 1'b1 : 1'b0, 1'b0}, 2'b00);
    end
`ifdef OUTC_CREDIT_CHK_EN
    check("cerr_sticky", 64'(cerr), 64'h1);
`endif

    // Open a packet on VC0, then reset mid-packet.
    clear_inputs();
    iack[0] = 1'b1;
    tick();
    tick();
    iack = '0;
    req[0] = 1'b1; ivalid[0] = 1'b1; ivch[0] = 1'b0; idata[0] = mk(T_HEAD, 34'h5A5);
    issue("grant_head_vc0", 5'b00001);
    clear_inputs();
    status("mid_packet", 2'b01, 2'b01);
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    status("async_reset", 2'b11, 2'b00);
    check("async_reset_ovalid", 64'(ovalid), 64'h0);
`ifdef OUTC_CREDIT_CHK_EN
    check("cerr_reset", 64'(cerr), 64'h0);
`endif
    @(posedge clk); #2;
    rst_ = 1'b1;
    tick();

    // Pointer restarts at 0 after reset.
    req[0] = 1'b1; req[3] = 1'b1; ivalid[0] = 1'b1; ivalid[3] = 1'b1;
    idata[0] = mk(T_HT, 34'h600); idata[3] = mk(T_HT, 34'h603);
    issue("rr_after_reset", 5'b00001);
    clear_inputs();
    tick();
    tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
